// File: rtl/led_serial_receiver_pkg.sv
// ----------------------------------------------------------------------------
// led_serial_receiver_pkg
//   Constants shared by the serial LED link blocks (driver, receiver,
//   DIP parallelizer), plus the commit-result type and the saturating
//   error-counter helper used by the receiver.
// ----------------------------------------------------------------------------
package led_serial_receiver_pkg;

    localparam int LED_FRAME_WIDTH = 16;
    localparam int LED_SYNC_STAGES = 2;
    localparam int LED_ERRCNT_W    = 8;

    localparam logic [LED_ERRCNT_W-1:0] LED_ERRCNT_MAX = '1;

    // Outcome of a latch edge in a given cycle.
    typedef enum logic [1:0] {
        COMMIT_NONE = 2'd0,
        COMMIT_GOOD = 2'd1,
        COMMIT_ERR  = 2'd2
    } commit_e;

    // Increment that sticks at all-ones.
    function automatic logic [LED_ERRCNT_W-1:0] errcnt_inc(input logic [LED_ERRCNT_W-1:0] c);
        return (c == LED_ERRCNT_MAX) ? c : c + LED_ERRCNT_W'(1);
    endfunction

endpackage

// File: rtl/led_serial_receiver_sync_rise_detect.sv
// ----------------------------------------------------------------------------
// sync_rise_detect
//   Brings one asynchronous link wire into the i_CLK domain through a
//   STAGES-deep flop chain and flags its rising edge.
// Ports
//   i_CLK      system clock
//   i_RESET_n  async active-low reset (already release-synchronized)
//   i_Async    raw link wire
//   o_Sync     synchronized level (last chain stage)
//   o_Rise     one-cycle high when o_Sync goes 0 -> 1
// ----------------------------------------------------------------------------
module sync_rise_detect
    import led_serial_receiver_pkg::*;
#(
    parameter int STAGES = LED_SYNC_STAGES
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_Async,
    output logic o_Sync,
    output logic o_Rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_Async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_Sync = r_sync[STAGES-1];
    // Edge is visible in the same cycle the new level leaves the chain.
    assign o_Rise = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/led_serial_receiver.sv
// ----------------------------------------------------------------------------
// led_serial_receiver
//   Receiving end of the serial LED link (shift clock / data / latch).
//   Oversamples the link on i_CLK, deserializes WIDTH-bit frames and, on
//   each latch rising edge, publishes a frame that had exactly WIDTH bits.
// Ports
//   i_CLK       system clock (>= 4x link shift clock)
//   i_RESET_n   async active-low reset, release synchronized internally
//   i_SCLK      link shift clock (async)
//   i_SData     link serial data, stable around i_SCLK rising edge
//   i_SLatch    link latch, rising edge commits
//   o_Data      last good frame
//   o_Valid     one-cycle pulse when o_Data updates
//   o_FrameErr  one-cycle pulse on a latch with bit count != WIDTH
//   o_ErrCount  saturating framing-error count
// ----------------------------------------------------------------------------
module led_serial_receiver
    import led_serial_receiver_pkg::*;
#(
    parameter int WIDTH       = LED_FRAME_WIDTH,
    parameter int SYNC_STAGES = LED_SYNC_STAGES,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET_n,
    input  logic                    i_SCLK,
    input  logic                    i_SData,
    input  logic                    i_SLatch,
    output logic [WIDTH-1:0]        o_Data,
    output logic                    o_Valid,
    output logic                    o_FrameErr,
    output logic [LED_ERRCNT_W-1:0] o_ErrCount
);

    localparam int               CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    // WIDTH+1 marks "too many bits"; the counter parks there.
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(WIDTH + 1);

    // Reset: asserts immediately, releases two i_CLK edges later.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) r_rst_sync <= '0;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // Link input synchronizers.
    logic w_sclk_sync, w_sclk_rise;
    logic w_sdata_sync, w_sdata_rise;
    logic w_latch_sync, w_latch_rise;
    logic w_unused;

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_CLK     (i_CLK),
        .i_RESET_n (w_rst_n),
        .i_Async   (i_SCLK),
        .o_Sync    (w_sclk_sync),
        .o_Rise    (w_sclk_rise)
    );

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .i_CLK     (i_CLK),
        .i_RESET_n (w_rst_n),
        .i_Async   (i_SData),
        .o_Sync    (w_sdata_sync),
        .o_Rise    (w_sdata_rise)
    );

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync_latch (
        .i_CLK     (i_CLK),
        .i_RESET_n (w_rst_n),
        .i_Async   (i_SLatch),
        .o_Sync    (w_latch_sync),
        .o_Rise    (w_latch_rise)
    );

    // Only the data level and the two rising edges are consumed.
    assign w_unused = w_sclk_sync ^ w_sdata_rise ^ w_latch_sync;

    // Datapath state.
    logic [WIDTH-1:0]        r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic [WIDTH-1:0]        r_data;
    logic                    r_valid;
    logic                    r_ferr;
    logic [LED_ERRCNT_W-1:0] r_errcnt;

    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    commit_e          w_commit;

    // Shift first, so a latch in the same cycle judges the updated frame.
    always_comb begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        if (w_sclk_rise) begin
            if (MSB_FIRST) w_shift_nxt = {r_shift[WIDTH-2:0], w_sdata_sync};
            else           w_shift_nxt = {w_sdata_sync, r_shift[WIDTH-1:1]};
            if (r_cnt != CNT_OVR) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_commit = COMMIT_NONE;
        if (w_latch_rise) w_commit = (w_cnt_nxt == CNT_FULL) ? COMMIT_GOOD : COMMIT_ERR;
    end

    always_ff @(posedge i_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_errcnt <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            r_cnt   <= (w_commit == COMMIT_NONE) ? w_cnt_nxt : '0;
            r_valid <= (w_commit == COMMIT_GOOD);
            r_ferr  <= (w_commit == COMMIT_ERR);
            if (w_commit == COMMIT_GOOD) r_data   <= w_shift_nxt;
            if (w_commit == COMMIT_ERR)  r_errcnt <= errcnt_inc(r_errcnt);
        end
    end

    assign o_Data     = r_data;
    assign o_Valid    = r_valid;
    assign o_FrameErr = r_ferr;
    assign o_ErrCount = r_errcnt;

endmodule
